// File: rtl/serial_sample_deser.sv
// serial_sample_deser
//   Serial audio receiver. The bit clock (clk_over3), serial data and lrck
//   are all sampled as data in the clk domain through matched synchronisers.
//   A word of DATA_W bits is collected MSB first from the lrck edge
//   (left-justified). The result is presented on a valid/ready output slot.
//
//   Optional build macro: DESER_STATUS_EN. It adds saturating frm_err/ovf
//   event counters and a counter clear input.
//
// Ports
//   clk        system clock (only clock)
//   nreset     asynchronous active-low reset
//   clk_over3  bit clock, synchronised and edge-detected
//   sdata      serial data, MSB first
//   lrck       channel select, 0 = left, 1 = right
//   out_data   received sample
//   out_chan   lrck level of the frame that produced out_data
//   out_valid  output slot holds a word
//   out_ready  consumer accepts on out_valid && out_ready
//   ovf        1-cycle pulse, completed word dropped (slot full)
//   frm_err    1-cycle pulse, lrck toggled mid-word
//   cnt_clr    (DESER_STATUS_EN) zero both event counters
//   err_cnt    (DESER_STATUS_EN) saturating frm_err count
//   ovf_cnt    (DESER_STATUS_EN) saturating ovf count
module serial_sample_deser #(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              clk_over3,
   input  logic              sdata,
   input  logic              lrck,
   output logic [DATA_W-1:0] out_data,
   output logic              out_chan,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              ovf,
   output logic              frm_err
`ifdef DESER_STATUS_EN
   ,
   input  logic              cnt_clr,
   output logic [7:0]        err_cnt,
   output logic [7:0]        ovf_cnt
`endif
);

   localparam int CW = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   logic [SYNC_STAGES-1:0] bclk_sync, sdat_sync, lrck_sync;
   logic                   bclk_s, sdat_s, lrck_s;
   logic                   bclk_d, lrck_prev, primed;
   logic                   tick, frame_start;

   state_t                 state, state_nxt;
   logic [DATA_W-1:0]      shreg;
   logic [CW-1:0]          cnt;
   logic                   chan;
   logic                   start_word, shift_bit, abort_word, load_word, drop_word;

   // All three inputs go through identical chains so they stay cycle-aligned.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         bclk_sync <= '0;
         sdat_sync <= '0;
         lrck_sync <= '0;
      end else begin
         bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], clk_over3};
         sdat_sync <= {sdat_sync[SYNC_STAGES-2:0], sdata};
         lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck};
      end
   end

   assign bclk_s = bclk_sync[SYNC_STAGES-1];
   assign sdat_s = sdat_sync[SYNC_STAGES-1];
   assign lrck_s = lrck_sync[SYNC_STAGES-1];

   // primed blocks the first tick after reset from looking like an lrck
   // edge: the reset value of lrck_prev is not a real observed level, so a
   // fresh toggle is required before the first word.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         bclk_d    <= 1'b0;
         lrck_prev <= 1'b0;
         primed    <= 1'b0;
      end else begin
         bclk_d <= bclk_s;
         if (tick) begin
            lrck_prev <= lrck_s;
            primed    <= 1'b1;
         end
      end
   end

   assign tick        = bclk_s & ~bclk_d;
   assign frame_start = tick & primed & (lrck_s != lrck_prev);

   // FSM: state register
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) state <= IDLE;
      else         state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (frame_start) state_nxt = SHIFT;
         SHIFT:   if (!frame_start && tick && cnt == CW'(DATA_W - 1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM: datapath controls
   always_comb begin
      start_word = 1'b0;
      shift_bit  = 1'b0;
      abort_word = 1'b0;
      load_word  = 1'b0;
      drop_word  = 1'b0;
      case (state)
         IDLE:  start_word = frame_start;
         SHIFT: begin
            start_word = frame_start;
            abort_word = frame_start;
            shift_bit  = tick & ~frame_start;
         end
         DONE: begin
            load_word = ~out_valid | out_ready;
            drop_word = out_valid & ~out_ready;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         shreg     <= '0;
         cnt       <= '0;
         chan      <= 1'b0;
         out_data  <= '0;
         out_chan  <= 1'b0;
         out_valid <= 1'b0;
         ovf       <= 1'b0;
         frm_err   <= 1'b0;
      end else begin
         ovf     <= drop_word;
         frm_err <= abort_word;
         if (start_word) begin
            // The bit that arrives with the lrck edge is the MSB.
            shreg <= {{(DATA_W-1){1'b0}}, sdat_s};
            cnt   <= CW'(1);
            chan  <= lrck_s;
         end else if (shift_bit) begin
            shreg <= {shreg[DATA_W-2:0], sdat_s};
            cnt   <= cnt + CW'(1);
         end
         if (load_word) begin
            out_data  <= shreg;
            out_chan  <= chan;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef DESER_STATUS_EN
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         err_cnt <= '0;
         ovf_cnt <= '0;
      end else if (cnt_clr) begin
         err_cnt <= '0;
         ovf_cnt <= '0;
      end else begin
         if (frm_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         if (ovf && ovf_cnt != 8'hFF)     ovf_cnt <= ovf_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_serial_sample_deser.sv
module tb_serial_sample_deser;
   localparam int DW  = 16;
   localparam int SS  = 2;
   localparam int LAT = SS + 2;   // raw LSB bit-clock rise to out_valid high

   logic          clk = 1'b0, nreset = 1'b0;
   logic          clk_over3 = 1'b0, sdata = 1'b0, lrck = 1'b0, out_ready = 1'b1;
   logic [DW-1:0] out_data;
   logic          out_chan, out_valid, ovf, frm_err;
`ifdef DESER_STATUS_EN
   logic          cnt_clr = 1'b0;
   logic [7:0]    err_cnt, ovf_cnt;
`endif

   serial_sample_deser #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
      .clk(clk), .nreset(nreset), .clk_over3(clk_over3), .sdata(sdata), .lrck(lrck),
      .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready),
`ifdef DESER_STATUS_EN
      .cnt_clr(cnt_clr), .err_cnt(err_cnt), .ovf_cnt(ovf_cnt),
`endif
      .ovf(ovf), .frm_err(frm_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [DW-1:0] data; logic chan; int rise; } exp_t;
   exp_t q[$];

   int n_tests = 0, n_fail = 0;
   int ovf_seen = 0, err_seen = 0;
   int exp_ovf = 0, exp_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every transfer, checks hold and pulse widths.
   logic          p_valid = 0, p_ready = 0, p_ovf = 0, p_err = 0, p_chan = 0;
   logic [DW-1:0] p_data = '0;
   int            rise_cyc = 0;
   always @(negedge clk) begin
      if (!nreset) begin
         p_valid = 0; p_ready = 0; p_ovf = 0; p_err = 0;
      end else begin
         if (out_valid && !p_valid) rise_cyc = cyc;
         if (p_valid && !p_ready) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, p_data);
            check("hold_chan", out_chan, p_chan);
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("unexpected_word", out_data, 32'hDEAD);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("word_data", out_data, e.data);
               check("word_chan", out_chan, e.chan);
               check("word_latency", rise_cyc, e.rise);
            end
         end
         if (ovf) begin ovf_seen++; check("ovf_single", p_ovf, 0); end
         if (frm_err) begin err_seen++; check("frm_err_single", p_err, 0); end
         p_valid = out_valid; p_ready = out_ready; p_data = out_data;
         p_chan = out_chan; p_ovf = ovf; p_err = frm_err;
      end
   end

   // One bit period = 3 clk cycles; bit clock high in the third.
   // Entered and left #1 after a posedge.
   task automatic send_bit(input logic l, input logic d, output int t);
      lrck = l; sdata = d; clk_over3 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      clk_over3 = 1'b1; t = cyc;
      @(posedge clk); #1;
   endtask

   task automatic send_bits(input logic l, input logic [DW-1:0] w, input int nb);
      int t;
      for (int i = DW - 1; i >= DW - nb; i--) send_bit(l, w[i], t);
   endtask

   task automatic send_word(input logic l, input logic [DW-1:0] w, input bit expect_out);
      int t;
      for (int i = DW - 1; i >= 0; i--) send_bit(l, w[i], t);
      if (expect_out) q.push_back('{data: w, chan: l, rise: t + LAT});
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      int t;
      // Reset state
      idle_cycles(3);
      @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_chan", out_chan, 0);
      check("rst_ovf", ovf, 0);
      check("rst_frm_err", frm_err, 0);
      @(posedge clk); #1; nreset = 1'b1;
      idle_cycles(2);

      // 1: lrck 0->1, word 0xA5C3 on right channel
      send_bits(1'b0, 16'h0000, 2);
      send_word(1'b1, 16'hA5C3, 1);

      // 2: back-to-back L/R/L
      send_word(1'b0, 16'h1234, 1);
      send_word(1'b1, 16'hBEEF, 1);
      send_word(1'b0, 16'h0F0F, 1);
      idle_cycles(8);

      // 3: consumer stalls; second word is dropped
      out_ready = 1'b0;
      send_word(1'b1, 16'h1111, 1);
      send_word(1'b0, 16'h2222, 0);
      exp_ovf++;
      idle_cycles(10);
      @(negedge clk);
      check("stall_data", out_data, 16'h1111);
      check("stall_valid", out_valid, 1);
      @(posedge clk); #1; out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("drain_valid", out_valid, 0);

      // 4: short frame of 9 bits, then a full word
      send_bits(1'b1, 16'hFFFF, 9);
      send_word(1'b0, 16'h8001, 1);
      exp_err++;
      idle_cycles(8);

      // 5: reset in the middle of bit 7 of a left-channel word
      send_word(1'b1, 16'h5A5A, 1);
      idle_cycles(8);
      send_bits(1'b0, 16'h6666, 8);
      lrck = 1'b0; sdata = 1'b1; clk_over3 = 1'b0;
      @(posedge clk); #1; nreset = 1'b0;
      #2;
      check("midrst_valid", out_valid, 0);
      check("midrst_data", out_data, 0);
      check("midrst_chan", out_chan, 0);
      @(posedge clk); #1; nreset = 1'b1;
      clk_over3 = 1'b1;
      @(posedge clk); #1;
      send_bits(1'b0, 16'h0000, 8);       // rest of the broken frame: ignored
      send_word(1'b1, 16'h3C96, 1);
      idle_cycles(8);

`ifdef DESER_STATUS_EN
      // 6: saturating status counters
      cnt_clr = 1'b1; @(posedge clk); #1; cnt_clr = 1'b0;
      @(negedge clk);
      check("clr_err_cnt", err_cnt, 0);
      check("clr_ovf_cnt", ovf_cnt, 0);
      @(posedge clk); #1;
      send_bits(1'b0, 16'h0000, 2);
      send_bits(1'b1, 16'h0000, 2);
      send_bits(1'b0, 16'h0000, 2);
      out_ready = 1'b0;
      send_word(1'b1, 16'h7E81, 1);
      exp_err += 3;
      for (int i = 0; i < 300; i++) send_word(i[0] ? 1'b1 : 1'b0, 16'h4321, 0);
      exp_ovf += 300;
      idle_cycles(4);
      @(negedge clk);
      check("err_cnt", err_cnt, 3);
      check("ovf_cnt_sat", ovf_cnt, 255);
      @(posedge clk); #1; cnt_clr = 1'b1; @(posedge clk); #1; cnt_clr = 1'b0;
      @(negedge clk);
      check("clr2_err_cnt", err_cnt, 0);
      check("clr2_ovf_cnt", ovf_cnt, 0);
      @(posedge clk); #1; out_ready = 1'b1;
      idle_cycles(4);
`endif

      idle_cycles(6);
      check("scoreboard_empty", q.size(), 0);
      check("ovf_total", ovf_seen, exp_ovf);
      check("frm_err_total", err_seen, exp_err);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
